// File: rtl/des_round_ctrl.sv
// Control sequencer for the iterative DES datapath: IP, 16 Feistel rounds, FP, then result handoff.
// Result valid 3+16*RC cycles after accept; out_valid holds until out_ready and no new block is accepted meanwhile.
module des_round_ctrl #(
  parameter int RC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       decrypt,
  input  logic       abort,
  output logic       ip_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       key_load,
  output logic [1:0] key_shift_amt,
  output logic       key_shift_dir,
  output logic       fp_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int SW = (RC > 1) ? $clog2(RC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(RC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IP    = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FP    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [3:0]    idx_q;
  logic [SW-1:0] sub_q;
  logic          mode_q;
  logic          round_last;

  assign round_last = (state == S_ROUND) && (sub_q == SUB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx_q  <= 4'd0;
      sub_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            state  <= S_IP;
            mode_q <= decrypt;
            idx_q  <= 4'd0;
            sub_q  <= '0;
          end
        end
        S_IP: state <= abort ? S_IDLE : S_ROUND;
        S_ROUND: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (sub_q == SUB_LAST) begin
            sub_q <= '0;
            // Index saturates at 15 so it reads as the last round through FP and DONE.
            if (idx_q == 4'd15) state <= S_FP;
            else                idx_q <= idx_q + 4'd1;
          end else begin
            sub_q <= sub_q + SW'(1);
          end
        end
        S_FP: state <= abort ? S_IDLE : S_DONE;
        S_DONE: begin
          if (abort || out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Abort silences every strobe in its own cycle so a cancelled block never commits anything.
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign ip_load     = (state == S_IP) && !abort;
  assign key_load    = ip_load;
  assign round_en    = round_last && !abort;
  assign fp_load     = (state == S_FP) && !abort;
  assign out_valid   = (state == S_DONE) && !abort;
  assign round_idx   = idx_q;

  always_comb begin
    key_shift_amt = 2'd0;
    key_shift_dir = 1'b0;
    if (round_en) begin
      key_shift_dir = mode_q;
      // Decrypt starts from the unrotated key, so its first round needs no shift.
      if (mode_q && (idx_q == 4'd0))
        key_shift_amt = 2'd0;
      else if (idx_q inside {4'd0, 4'd1, 4'd8, 4'd15})
        key_shift_amt = 2'd1;
      else
        key_shift_amt = 2'd2;
    end
  end

endmodule
